// File: rtl/prescaled_mod_counter_pkg.sv
// ============================================================================
// Module  : prescaled_mod_counter_pkg
// Brief   : Shared mode and reset-value constants for prescaled_mod_counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prescaled_mod_counter_pkg;

  // Direction select (increment input)
  localparam logic COUNT_DOWN    = 1'b0;
  localparam logic COUNT_UP      = 1'b1;

  // Terminal behaviour select (saturate input)
  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;

  // Reset values of the registered state
  localparam logic RST_TC        = 1'b0;
  localparam logic RST_AT_ZERO   = 1'b1;

  // Combined {increment, saturate} selector used by the next-count case
  typedef enum logic [1:0] {
    SEL_DOWN_WRAP = {COUNT_DOWN, MODE_WRAP},
    SEL_DOWN_SAT  = {COUNT_DOWN, MODE_SATURATE},
    SEL_UP_WRAP   = {COUNT_UP,   MODE_WRAP},
    SEL_UP_SAT    = {COUNT_UP,   MODE_SATURATE}
  } count_sel_t;

endpackage

`default_nettype wire

// File: rtl/prescaled_mod_counter_tick_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Brief   : Divides enabled cycles by prescale+1 and emits a one-cycle tick.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      w_terminal;

  // >= rather than == so a prescale reduced below the current phase still ticks
  assign w_terminal = (r_pre >= prescale);
  assign tick       = enable & w_terminal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (enable) begin
      if (clear || w_terminal) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/prescaled_mod_counter.sv
// ============================================================================
// Module  : prescaled_mod_counter
// Brief   : Up/down counter with programmable modulus, prescaler, wrap or
//           saturate terminal behaviour, synchronous load and tc pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaled_mod_counter
  import prescaled_mod_counter_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [WIDTH-1:0]          D,
  input  logic                      increment,
  input  logic                      saturate,
  input  logic [WIDTH-1:0]          modulus,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          Q,
  output logic                      tc,
  output logic                      at_zero,
  output logic                      at_max
);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             w_tick;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;
  logic             w_is_zero;
  logic             w_above_max;
  logic             w_at_or_above_max;
  count_sel_t       w_sel;

  tick_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_tick_prescaler (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (load),
    .prescale (prescale),
    .tick     (w_tick)
  );

  assign w_is_zero         = (r_q == '0);
  assign w_above_max       = (r_q > modulus);
  assign w_at_or_above_max = (r_q >= modulus);
  assign w_sel             = count_sel_t'({increment, saturate});

  // Count applied on a tick; terminal checks keep Q inside 0..modulus
  always_comb begin
    w_q_next  = r_q;
    w_tc_next = 1'b0;
    case (w_sel)
      SEL_UP_WRAP: begin
        if (w_at_or_above_max) begin
          w_q_next  = '0;
          w_tc_next = 1'b1;
        end else begin
          w_q_next  = r_q + 1'b1;
        end
      end
      SEL_UP_SAT: begin
        if (w_at_or_above_max) begin
          w_q_next  = modulus;
          w_tc_next = 1'b1;
        end else begin
          w_q_next  = r_q + 1'b1;
        end
      end
      SEL_DOWN_WRAP: begin
        if (w_is_zero) begin
          w_q_next  = modulus;
          w_tc_next = 1'b1;
        end else if (w_above_max) begin
          w_q_next  = modulus;
        end else begin
          w_q_next  = r_q - 1'b1;
        end
      end
      SEL_DOWN_SAT: begin
        if (w_is_zero) begin
          w_q_next  = '0;
          w_tc_next = 1'b1;
        end else if (w_above_max) begin
          w_q_next  = modulus;
        end else begin
          w_q_next  = r_q - 1'b1;
        end
      end
      default: begin
        w_q_next  = r_q;
        w_tc_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q  <= '0;
      r_tc <= RST_TC;
    end else if (enable) begin
      if (load) begin
        r_q  <= D;
        r_tc <= 1'b0;
      end else if (w_tick) begin
        r_q  <= w_q_next;
        r_tc <= w_tc_next;
      end else begin
        r_tc <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign Q       = r_q;
  assign tc      = r_tc;
  assign at_zero = w_is_zero ? RST_AT_ZERO : ~RST_AT_ZERO;
  assign at_max  = (r_q == modulus);

endmodule

`default_nettype wire

// File: tb/tb_prescaled_mod_counter.sv
// ============================================================================
// Module  : tb_prescaled_mod_counter
// Brief   : Directed self-checking bench for prescaled_mod_counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prescaled_mod_counter;

  localparam int WIDTH          = 8;
  localparam int PRESCALE_WIDTH = 4;

  logic                      clk;
  logic                      rst;
  logic                      enable;
  logic                      load;
  logic [WIDTH-1:0]          D;
  logic                      increment;
  logic                      saturate;
  logic [WIDTH-1:0]          modulus;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]          Q;
  logic                      tc;
  logic                      at_zero;
  logic                      at_max;

  int total = 0;
  int bad   = 0;

  prescaled_mod_counter #(
    .WIDTH          (WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .D         (D),
    .increment (increment),
    .saturate  (saturate),
    .modulus   (modulus),
    .prescale  (prescale),
    .Q         (Q),
    .tc        (tc),
    .at_zero   (at_zero),
    .at_max    (at_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] val);
    load = 1'b1;
    D    = val;
    edge1();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; load = 1'b0; D = '0;
    increment = 1'b1; saturate = 1'b0; modulus = 8'd9; prescale = 4'd2;

    // Reset held with activity on inputs
    #2;
    enable = 1'b1;
    repeat (3) edge1();
    check("rst_q", Q, 0);
    check("rst_tc", tc, 0);
    check("rst_at_zero", at_zero, 1);
    check("rst_at_max", at_max, 0);

    // Wrap up, modulus 9, prescale 0
    prescale = 4'd0;
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      edge1();
      check($sformatf("wrap_q_%0d", i), Q, i);
      check($sformatf("wrap_tc_%0d", i), tc, 0);
    end
    check("wrap_at_max9", at_max, 1);
    edge1();
    check("wrap_q_0", Q, 0);
    check("wrap_tc_0", tc, 1);
    edge1();
    check("wrap_q_1b", Q, 1);
    check("wrap_tc_1b", tc, 0);

    // Prescale 3: advance every 4th edge
    prescale = 4'd3;
    for (int i = 1; i <= 8; i++) begin
      edge1();
      check($sformatf("ps3_q_%0d", i), Q, (i < 4) ? 1 : (i < 8) ? 2 : 3);
    end

    // Asynchronous reset mid-count at Q = 5
    prescale = 4'd2;
    do_load(8'd5);
    check("load5_q", Q, 5);
    edge1();
    check("hold5_q", Q, 5);
    rst = 1'b0;
    #1;
    check("async_rst_q", Q, 0);
    check("async_rst_at_zero", at_zero, 1);
    edge1();
    rst = 1'b1;
    edge1();
    check("post_rst_e1", Q, 0);
    edge1();
    check("post_rst_e2", Q, 0);
    edge1();
    check("post_rst_e3", Q, 1);

    // Saturate down from 2
    increment = 1'b0; saturate = 1'b1; prescale = 4'd0;
    do_load(8'd2);
    check("satdn_load_q", Q, 2);
    check("satdn_load_tc", tc, 0);
    edge1();
    check("satdn_q1", Q, 1);
    check("satdn_tc1", tc, 0);
    edge1();
    check("satdn_q2", Q, 0);
    check("satdn_tc2", tc, 0);
    edge1();
    check("satdn_q3", Q, 0);
    check("satdn_tc3", tc, 1);
    edge1();
    check("satdn_q4", Q, 0);
    check("satdn_tc4", tc, 1);

    // Load priority over a tick, D above modulus
    increment = 1'b1; saturate = 1'b0; modulus = 8'd50;
    do_load(8'd4);
    check("lp_q4", Q, 4);
    do_load(8'd200);
    check("lp_q200", Q, 200);
    check("lp_tc_load", tc, 0);
    edge1();
    check("lp_up_q", Q, 0);
    check("lp_up_tc", tc, 1);
    do_load(8'd200);
    check("lp_q200b", Q, 200);
    increment = 1'b0;
    edge1();
    check("lp_dn_q", Q, 50);
    check("lp_dn_tc", tc, 0);
    check("lp_dn_at_max", at_max, 1);

    // Enable gating mid-prescale
    increment = 1'b1; prescale = 4'd1;
    do_load(8'd10);
    edge1();
    check("eg_phase_q", Q, 10);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      check($sformatf("eg_frozen_%0d", i), Q, 10);
    end
    load = 1'b1; D = 8'd77;
    edge1();
    load = 1'b0;
    check("eg_load_off", Q, 10);
    enable = 1'b1;
    edge1();
    check("eg_resume1", Q, 11);
    edge1();
    check("eg_resume2", Q, 11);
    edge1();
    check("eg_resume3", Q, 12);

    // modulus 0: tc on every enabled tick in all modes
    modulus = 8'd0; prescale = 4'd0;
    do_load(8'd0);
    for (int m = 0; m < 4; m++) begin
      increment = m[1];
      saturate  = m[0];
      for (int k = 0; k < 2; k++) begin
        edge1();
        check($sformatf("m0_q_%0d_%0d", m, k), Q, 0);
        check($sformatf("m0_tc_%0d_%0d", m, k), tc, 1);
      end
    end
    check("m0_at_max", at_max, 1);
    enable = 1'b0;
    edge1();
    check("m0_dis_tc", tc, 0);
    check("m0_dis_q", Q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prescaled_mod_counter.md
# prescaled_mod_counter

Parametrised up/down counter with programmable modulus, clock prescaler, wrap or saturate mode, synchronous load and a registered terminal-count pulse. It generalises the team's basic load/increment/enable counter for timers, baud/tick generators and address sequencers, and sits wherever glue logic needs a periodic event or a bounded count rather than a free-running binary counter.

## Interface
Parameters:
- WIDTH, 8: counter width; Q, D and modulus are WIDTH bits.
- PRESCALE_WIDTH, 4: width of the prescale divisor; 0 is legal and means no division.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately; release is synchronous to clk.
- enable  in  1  gates prescaler, counting and load.
- load  in  1  synchronous load of D; effective only with enable high.
- D  in  WIDTH  load value.
- increment  in  1  1 = count up, 0 = count down; sampled on every tick.
- saturate  in  1  0 = wrap mode, 1 = saturate mode.
- modulus  in  WIDTH  terminal (maximum) count value; the count range is 0..modulus.
- prescale  in  PRESCALE_WIDTH  a tick occurs every prescale+1 enabled cycles.
- Q  out  WIDTH  current count; reset value 0.
- tc  out  1  registered one-cycle terminal-count pulse; reset value 0.
- at_zero  out  1  Q == 0, decoded from registers; reset value 1.
- at_max  out  1  Q == modulus, combinational compare; reset value (modulus == 0).

## Operation
- Prescaler: internal count pre, range 0..prescale. While enable is high, tick = (pre == prescale). On a tick, pre goes to 0; otherwise pre increments. If pre > prescale after prescale is reduced, the prescaler treats it as a tick.
- enable low: pre, Q and tc hold their values, except that tc is forced to 0 on the next edge.
- Priority on an enabled cycle: load first, then tick, then hold.
- Load: Q <= D and pre <= 0, with no tick and no tc. A D value above modulus is accepted unchanged.
- Tick, counting up:
  - If Q >= modulus: in wrap mode Q <= 0; in saturate mode Q <= modulus. tc pulses in both modes.
  - Otherwise Q <= Q + 1.
- Tick, counting down:
  - If Q == 0: in wrap mode Q <= modulus; in saturate mode Q holds at 0. tc pulses in both modes.
  - If Q > modulus: Q <= modulus with no tc.
  - Otherwise Q <= Q - 1.
- Arithmetic is unsigned modulo 2^WIDTH. Because the terminal checks above catch the edge values, Q never carries out of or borrows below its range.
- In saturate mode, tc pulses on every tick that arrives while Q is held at the terminal value.
- modulus == 0: Q stays at 0 and tc pulses on every tick, in either direction.
- increment, saturate, modulus and prescale may change on any cycle. The values present at an edge govern that edge.

## Timing
- Load latency is one cycle: Q = D on the edge where load and enable are both high.
- Tick cadence: with enable held high from pre = 0, Q first changes on edge prescale+1 and then every prescale+1 edges after that.
- tc is registered on the same edge that applies the terminal update, so tc is high during the cycle in which the wrapped or held Q is visible. It is never high for two consecutive cycles unless prescale == 0.
- rst low mid-count clears Q, pre and tc asynchronously. The first tick after rst is released occurs prescale+1 enabled edges later.

## Structure
- Shared package holds the mode constants COUNT_DOWN = 0, COUNT_UP = 1, MODE_WRAP = 0 and MODE_SATURATE = 1, plus the reset-value constants.
- One sub-module, tick_prescaler (clk, rst, enable, clear, prescale, tick), implements the prescale counter. Its clear input is driven by load.
- Next-state logic for Q stays in the top level as a single case on {increment, saturate}.

## Test plan
- Reset: hold rst low, then drive enable, increment and prescale = 2. Required: Q = 0, tc = 0, at_zero = 1. Assert rst low mid-count at Q = 5: Q drops to 0 immediately, without waiting for a clock edge.
- Wrap up: WIDTH = 8, modulus = 9, prescale = 0, up, wrap. Required: Q steps 0..9 then 0, with tc high only during the cycle Q first reads 0 after 9. Repeat with prescale = 3: Q advances every 4th edge.
- Saturate down: load D = 2, then down, saturate, prescale = 0. Required: Q reads 1, 0, 0, 0, with tc high on each cycle Q reads 0 after the first decrement.
- Load priority: at Q = 4, assert load with D = 200, modulus = 50, enable high, on a tick edge. Required: Q = 200 and no tc. Then the next tick up gives Q = 0 with tc; a tick down instead gives Q = 50 with no tc.
- Enable gating: count up, prescale = 1, drop enable for 5 cycles mid-prescale. Required: Q and the prescaler phase are frozen, and the tick resumes exactly where it left off. Also, load with enable low has no effect.
- modulus = 0 with prescale = 0: Required: Q stays 0 and tc is high on every enabled cycle, in both directions and both modes.
